// File: rtl/yuv_capture_ctrl_if.sv
// Handshake bundle for yuv_capture_ctrl: software control, camera pixel bus, converter and FIFO.
// With YUV_CROP_EN defined the bundle also carries the crop-window inputs.
interface yuv_capture_ctrl_if #(
  parameter int unsigned CNT_W = 12
);
  logic                 cap_start;
  logic                 cap_busy;
  logic                 cap_done;
  logic                 cap_err;
  logic                 cam_vsync;
  logic                 pix_valid;
  logic [15:0]          pix_data;
  logic                 fifo_afull;
  logic                 rgb_wr_en;
  logic [15:0]          rgb_in;
  logic                 yuv_wr_en;
  logic [CNT_W*2-1:0]   pix_cnt;
`ifdef YUV_CROP_EN
  logic [CNT_W-1:0]     crop_x0;
  logic [CNT_W-1:0]     crop_y0;
  logic [CNT_W-1:0]     crop_w;
  logic [CNT_W-1:0]     crop_h;
`endif

  modport master (
    input  cap_start, cam_vsync, pix_valid, pix_data, fifo_afull, yuv_wr_en,
`ifdef YUV_CROP_EN
    input  crop_x0, crop_y0, crop_w, crop_h,
`endif
    output cap_busy, cap_done, cap_err, rgb_wr_en, rgb_in, pix_cnt
  );

  modport slave (
    output cap_start, cam_vsync, pix_valid, pix_data, fifo_afull, yuv_wr_en,
`ifdef YUV_CROP_EN
    output crop_x0, crop_y0, crop_w, crop_h,
`endif
    input  cap_busy, cap_done, cap_err, rgb_wr_en, rgb_in, pix_cnt
  );
endinterface

// File: rtl/yuv_capture_ctrl.sv
// Single-frame capture sequencer between the camera pixel bus and the rgb2yuv converter.
// Optional crop window enabled by defining YUV_CROP_EN.
module yuv_capture_ctrl #(
  parameter int unsigned H_ACT    = 640,
  parameter int unsigned V_ACT    = 480,
  parameter int unsigned CNT_W    = 12,
  parameter int unsigned PEND_W   = 4,
  parameter int unsigned DRAIN_TO = 64
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  yuv_capture_ctrl_if.master  cap_if
);
  localparam int unsigned PC_W = 2 * CNT_W;
  localparam int unsigned TO_W = (DRAIN_TO > 1) ? $clog2(DRAIN_TO) : 1;

  typedef enum logic [1:0] {IDLE, ARM, CAPT, DRAIN} state_e;

  state_e            state_q, state_d;
  logic              vsync_q;
  logic [CNT_W-1:0]  h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0]  v_cnt_q, v_cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [PC_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic              err_q, err_d;
  logic              wr_q, wr_d;
  logic [15:0]       rgb_q, rgb_d;
  logic              done;
  logic              vs_rise;
  logic              in_win;

  assign vs_rise = cap_if.cam_vsync & ~vsync_q;

`ifdef YUV_CROP_EN
  logic [CNT_W-1:0] crop_x0_q, crop_y0_q, crop_w_q, crop_h_q;
  logic [CNT_W:0]   x_end, y_end;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      crop_x0_q <= '0;
      crop_y0_q <= '0;
      crop_w_q  <= '0;
      crop_h_q  <= '0;
    end else if (state_q == IDLE && cap_if.cap_start) begin
      crop_x0_q <= cap_if.crop_x0;
      crop_y0_q <= cap_if.crop_y0;
      crop_w_q  <= cap_if.crop_w;
      crop_h_q  <= cap_if.crop_h;
    end
  end

  // One extra bit so origin+size never wraps back into the window.
  assign x_end  = {1'b0, crop_x0_q} + {1'b0, crop_w_q};
  assign y_end  = {1'b0, crop_y0_q} + {1'b0, crop_h_q};
  assign in_win = ({1'b0, h_cnt_q} >= {1'b0, crop_x0_q}) && ({1'b0, h_cnt_q} < x_end) &&
                  ({1'b0, v_cnt_q} >= {1'b0, crop_y0_q}) && ({1'b0, v_cnt_q} < y_end);
`else
  assign in_win = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    pend_d    = pend_q;
    to_d      = '0;
    pix_cnt_d = pix_cnt_q;
    err_d     = err_q;
    wr_d      = 1'b0;
    rgb_d     = rgb_q;
    done      = 1'b0;

    unique case ({wr_q, cap_if.yuv_wr_en})
      2'b10: if (pend_q == '1) err_d = 1'b1; else pend_d = pend_q + PEND_W'(1);
      2'b01: if (pend_q == '0) err_d = 1'b1; else pend_d = pend_q - PEND_W'(1);
      default: ;
    endcase

    unique case (state_q)
      IDLE: begin
        if (cap_if.cap_start) begin
          state_d   = ARM;
          err_d     = 1'b0;
          pix_cnt_d = '0;
          h_cnt_d   = '0;
          v_cnt_d   = '0;
          pend_d    = '0;
        end
      end
      ARM: begin
        if (vs_rise) state_d = CAPT;
      end
      CAPT: begin
        if (vs_rise) begin
          err_d   = 1'b1;
          state_d = DRAIN;
        end else if (cap_if.pix_valid) begin
          if (in_win) begin
            if (cap_if.fifo_afull) begin
              err_d = 1'b1;
            end else begin
              wr_d  = 1'b1;
              rgb_d = cap_if.pix_data;
              if (pix_cnt_q != '1) pix_cnt_d = pix_cnt_q + PC_W'(1);
            end
          end
          if (h_cnt_q == CNT_W'(H_ACT - 1)) begin
            h_cnt_d = '0;
            if (v_cnt_q == CNT_W'(V_ACT - 1)) begin
              v_cnt_d = '0;
              state_d = DRAIN;
            end else begin
              v_cnt_d = v_cnt_q + CNT_W'(1);
            end
          end else begin
            h_cnt_d = h_cnt_q + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        to_d = to_q + TO_W'(1);
        // A write still in its output register counts as pending.
        if (pend_q == '0 && !wr_q) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (to_q == TO_W'(DRAIN_TO - 1)) begin
          done    = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      vsync_q   <= 1'b0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      pend_q    <= '0;
      to_q      <= '0;
      pix_cnt_q <= '0;
      err_q     <= 1'b0;
      wr_q      <= 1'b0;
      rgb_q     <= '0;
    end else begin
      state_q   <= state_d;
      vsync_q   <= cap_if.cam_vsync;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      pend_q    <= pend_d;
      to_q      <= to_d;
      pix_cnt_q <= pix_cnt_d;
      err_q     <= err_d;
      wr_q      <= wr_d;
      rgb_q     <= rgb_d;
    end
  end

  assign cap_if.cap_busy  = (state_q != IDLE);
  assign cap_if.cap_done  = done;
  assign cap_if.cap_err   = err_q;
  assign cap_if.rgb_wr_en = wr_q;
  assign cap_if.rgb_in    = rgb_q;
  assign cap_if.pix_cnt   = pix_cnt_q;
endmodule

// File: tb/tb_yuv_capture_ctrl.sv
// Self-checking bench for yuv_capture_ctrl on a 4x2 frame with a converter echo model.
// Define YUV_CROP_EN to add the crop-window capture.
module tb_yuv_capture_ctrl;
  localparam int unsigned H_ACT    = 4;
  localparam int unsigned V_ACT    = 2;
  localparam int unsigned CNT_W    = 12;
  localparam int unsigned PEND_W   = 4;
  localparam int unsigned DRAIN_TO = 16;
  localparam int unsigned NPIX     = H_ACT * V_ACT;

  logic sys_clk = 1'b0;
  logic sys_rst;

  yuv_capture_ctrl_if #(.CNT_W(CNT_W)) cif ();

  yuv_capture_ctrl #(
    .H_ACT(H_ACT), .V_ACT(V_ACT), .CNT_W(CNT_W), .PEND_W(PEND_W), .DRAIN_TO(DRAIN_TO)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .cap_if (cif.master)
  );

  always #5 sys_clk = ~sys_clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned cyc_n   = 0;
  int unsigned done_cnt;
  int unsigned last_done_cyc;
  int unsigned last_pix_cyc;
  logic        echo_en;
  logic [1:0]  echo_pipe;
  logic [15:0] exp_q[$];
  int unsigned exp_cyc_q[$];
  logic [15:0] got_q[$];
  int unsigned got_cyc_q[$];
  int          crop_x0 = 0, crop_y0 = 0, crop_w = 0, crop_h = 0;
  bit          crop_on = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: observe outputs after the edge, then run the 2-cycle converter echo.
  task automatic step();
    @(posedge sys_clk);
    #1;
    cyc_n++;
    if (cif.rgb_wr_en === 1'b1) begin
      got_q.push_back(cif.rgb_in);
      got_cyc_q.push_back(cyc_n);
    end
    if (cif.cap_done === 1'b1) begin
      done_cnt++;
      last_done_cyc = cyc_n;
    end
    cif.yuv_wr_en = echo_en & echo_pipe[1];
    echo_pipe     = {echo_pipe[0], cif.rgb_wr_en};
  endtask

  function automatic bit in_window(input int unsigned idx);
    int h, v;
    h = int'(idx % H_ACT);
    v = int'(idx / H_ACT);
    if (!crop_on) return 1'b1;
    return (h >= crop_x0) && (h < crop_x0 + crop_w) && (v >= crop_y0) && (v < crop_y0 + crop_h);
  endfunction

  // Frame-relative pixel idx; forwarded when in-window and FIFO not almost full.
  task automatic pix(input int unsigned idx, input logic [15:0] d, input logic afull, input bit counts);
    cif.pix_valid  = 1'b1;
    cif.pix_data   = d;
    cif.fifo_afull = afull;
    if (counts && !afull && in_window(idx)) begin
      exp_q.push_back(d);
      exp_cyc_q.push_back(cyc_n + 1);
    end
    step();
    last_pix_cyc   = cyc_n;
    cif.pix_valid  = 1'b0;
    cif.fifo_afull = 1'b0;
    cif.cap_start  = 1'b0;
  endtask

  task automatic clear_log();
    exp_q.delete(); exp_cyc_q.delete(); got_q.delete(); got_cyc_q.delete();
    done_cnt = 0;
  endtask

  task automatic run_frame(input string nm, input int unsigned nsent, input int drop_idx, input int busy_idx);
    int unsigned budget;
    clear_log();
    cif.cap_start = 1'b1;
    step();
    cif.cap_start = 1'b0;
    chk({nm, "_busy_armed"}, cif.cap_busy, 1);
    chk({nm, "_err_cleared"}, cif.cap_err, 0);
    chk({nm, "_cnt_cleared"}, cif.pix_cnt, 0);
    for (int i = 0; i < 2; i++) pix(0, 16'($urandom), 1'b0, 1'b0);
    cif.cam_vsync = 1'b1;
    pix(0, 16'($urandom), 1'b0, 1'b0);
    cif.cam_vsync = 1'b0;
    for (int unsigned i = 0; i < nsent; i++) begin
      repeat ($urandom_range(0, 2)) step();
      if (int'(i) == busy_idx) cif.cap_start = 1'b1;
      pix(i, 16'h1234 + 16'(i) + 16'($urandom_range(0, 255) << 8), (int'(i) == drop_idx), 1'b1);
    end
    if (nsent < NPIX) begin
      cif.cam_vsync = 1'b1;
      pix(nsent, 16'($urandom), 1'b0, 1'b0);
      last_pix_cyc  = cyc_n;
      cif.cam_vsync = 1'b0;
    end
    budget = 0;
    while (done_cnt == 0 && budget < 200) begin
      step();
      budget++;
    end
    chk({nm, "_done_in_budget"}, (done_cnt != 0), 1);
    repeat (3) step();
    chk({nm, "_done_once"}, done_cnt, 1);
    chk({nm, "_idle"}, cif.cap_busy, 0);
  endtask

  task automatic check_fwd(input string nm);
    chk({nm, "_fwd_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_data%0d", nm, i), got_q[i], exp_q[i]);
      chk($sformatf("%s_lat%0d", nm, i), got_cyc_q[i], exp_cyc_q[i]);
    end
  endtask

  initial begin
    sys_rst        = 1'b1;
    cif.cap_start  = 1'b0;
    cif.cam_vsync  = 1'b0;
    cif.pix_valid  = 1'b0;
    cif.pix_data   = '0;
    cif.fifo_afull = 1'b0;
    cif.yuv_wr_en  = 1'b0;
`ifdef YUV_CROP_EN
    cif.crop_x0 = '0; cif.crop_y0 = '0; cif.crop_w = '0; cif.crop_h = '0;
`endif
    echo_en   = 1'b1;
    echo_pipe = '0;
    clear_log();
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_busy", cif.cap_busy, 0);
    chk("rst_done", cif.cap_done, 0);
    chk("rst_err", cif.cap_err, 0);
    chk("rst_wr", cif.rgb_wr_en, 0);
    chk("rst_rgb", cif.rgb_in, 0);
    chk("rst_cnt", cif.pix_cnt, 0);
    sys_rst = 1'b0;
    step();

    run_frame("full", NPIX, -1, -1);
    check_fwd("full");
    chk("full_cnt", cif.pix_cnt, NPIX);
    chk("full_err", cif.cap_err, 0);

    run_frame("afull", NPIX, 2, 4);
    check_fwd("afull");
    chk("afull_cnt", cif.pix_cnt, NPIX - 1);
    chk("afull_err_sticky", cif.cap_err, 1);

    run_frame("short", 5, -1, -1);
    check_fwd("short");
    chk("short_cnt", cif.pix_cnt, 5);
    chk("short_err", cif.cap_err, 1);

    echo_en = 1'b0;
    run_frame("tmo", NPIX, -1, -1);
    check_fwd("tmo");
    chk("tmo_drain_cycles", last_done_cyc - last_pix_cyc + 1, DRAIN_TO);
    chk("tmo_err", cif.cap_err, 1);
    echo_en = 1'b1;

    run_frame("again", NPIX, -1, -1);
    chk("again_cnt", cif.pix_cnt, NPIX);
    chk("again_err", cif.cap_err, 0);

`ifdef YUV_CROP_EN
    crop_on = 1'b1; crop_x0 = 1; crop_y0 = 1; crop_w = 2; crop_h = 1;
    cif.crop_x0 = 12'd1; cif.crop_y0 = 12'd1; cif.crop_w = 12'd2; cif.crop_h = 12'd1;
    run_frame("crop", NPIX, -1, -1);
    check_fwd("crop");
    chk("crop_cnt", cif.pix_cnt, 2);
    chk("crop_err", cif.cap_err, 0);
    crop_on = 1'b0;
    cif.crop_w = '0; cif.crop_h = '0;
`endif

    clear_log();
    cif.cap_start = 1'b1;
    step();
    cif.cap_start = 1'b0;
    cif.cam_vsync = 1'b1;
    step();
    cif.cam_vsync = 1'b0;
    pix(0, 16'hBEEF, 1'b1, 1'b1);
    pix(1, 16'hCAFE, 1'b0, 1'b1);
    chk("pre_rst_wr", cif.rgb_wr_en, 1);
    chk("pre_rst_err", cif.cap_err, 1);
    #2;
    sys_rst = 1'b1;
    #1;
    chk("mid_rst_busy", cif.cap_busy, 0);
    chk("mid_rst_done", cif.cap_done, 0);
    chk("mid_rst_err", cif.cap_err, 0);
    chk("mid_rst_wr", cif.rgb_wr_en, 0);
    chk("mid_rst_rgb", cif.rgb_in, 0);
    chk("mid_rst_cnt", cif.pix_cnt, 0);
    step();
    sys_rst       = 1'b0;
    echo_pipe     = '0;
    cif.yuv_wr_en = 1'b0;
    step();
    chk("post_rst_idle", cif.cap_busy, 0);

    run_frame("post", NPIX, -1, -1);
    check_fwd("post");
    chk("post_cnt", cif.pix_cnt, NPIX);
    chk("post_err", cif.cap_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
